// File: rtl/conv3x3_sequencer_if.sv
// -----------------------------------------------------------------------------
// conv3x3_sequencer_if
//
// Groups the two buses of the 3x3 convolution sequencer:
//   load bus : ld_valid / ld_ready / ld_data.
//              This is a valid/ready stream of pixel and weight words
//              flowing into the sequencer.
//   MAC bus  : mac_en / mac_clr / mac_a / mac_b go out to the shared
//              multiply-accumulate datapath. mac_acc is that datapath's
//              registered accumulator, returned to the sequencer.
//
// Modports
//   master : the sequencer side. It consumes load words and drives the MAC.
//   slave  : the environment side. It supplies load words and owns the MAC.
// -----------------------------------------------------------------------------
interface conv3x3_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 20
);

  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;

  logic          mac_en;
  logic          mac_clr;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [AW-1:0] mac_acc;

  modport master (
    input  ld_valid,
    input  ld_data,
    input  mac_acc,
    output ld_ready,
    output mac_en,
    output mac_clr,
    output mac_a,
    output mac_b
  );

  modport slave (
    output ld_valid,
    output ld_data,
    output mac_acc,
    input  ld_ready,
    input  mac_en,
    input  mac_clr,
    input  mac_a,
    input  mac_b
  );

endinterface

// File: rtl/conv3x3_sequencer.sv
// -----------------------------------------------------------------------------
// conv3x3_sequencer
//
// Sequences a 2x2 "valid" convolution of a 4x4 image with a 3x3 filter.
// The multiplies are done on an external, shared MAC datapath.
//
// Job flow
//   IDLE -> LOAD : on start.
//   LOAD -> RUN  : after 25 accepted words.
//                  Words 0..15 are image pixels (row-major).
//                  Words 16..24 are filter weights (row-major).
//   RUN  -> WAIT : after 36 taps.
//                  There are 4 windows of 9 taps each.
//                  Window order is (0,0),(0,1),(1,0),(1,1).
//   WAIT -> DONE : captures the last window.
//   DONE -> IDLE : done pulses for this single cycle.
//
// The MAC accumulator lags mac_en by one edge.
// So each window's sum becomes visible in the cycle after its 9th tap.
// That cycle is the next window's clear tap, or WAIT for the last window.
// The sum is captured there, truncated to DW bits.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : asynchronous, active-low reset
//   start        : job request, honoured in IDLE only
//   busy         : high in LOAD, RUN, WAIT
//   done         : one-cycle pulse once all four results are valid
//   bus          : load stream + MAC datapath (master modport)
//   o00..o11     : window results; each holds until the next job rewrites it
// -----------------------------------------------------------------------------
module conv3x3_sequencer #(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  conv3x3_sequencer_if.master  bus,
  output logic [DW-1:0]        o00,
  output logic [DW-1:0]        o01,
  output logic [DW-1:0]        o10,
  output logic [DW-1:0]        o11
);

  // A 9-tap sum of DW x DW products needs 2*DW+4 bits to avoid wrapping.
  if (AW < 2*DW + 4) begin : g_aw_check
    $error("conv3x3_sequencer: AW must be at least 2*DW+4");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t        state;
  logic [4:0]    ld_idx;     // next load word index, 0..24
  logic [1:0]    win;        // window currently presented: {r, c}
  logic [1:0]    ti;         // filter row of the tap currently presented
  logic [1:0]    tj;         // filter column of the tap currently presented

  logic [DW-1:0] img [16];
  logic [DW-1:0] flt [9];

  // Position of the tap that follows (win, ti, tj).
  logic [1:0]    nx_win;
  logic [1:0]    nx_ti;
  logic [1:0]    nx_tj;
  logic          last_tap;

  logic [DW-1:0] acc_lo;
  logic          unused_acc_hi;

  // Only the low DW bits of the accumulator are kept.
  assign acc_lo        = bus.mac_acc[DW-1:0];
  assign unused_acc_hi = ^bus.mac_acc[AW-1:DW];

  // Pixel address for window (r,c) = w and tap (i,j).
  // The address is (r+i)*4 + (c+j).
  // Row and column each fit in two bits, so the address is just {row, col}.
  function automatic logic [3:0] pix_addr(
    input logic [1:0] w,
    input logic [1:0] i,
    input logic [1:0] j
  );
    logic [1:0] row;
    logic [1:0] col;
    row = {1'b0, w[1]} + i;
    col = {1'b0, w[0]} + j;
    return {row, col};
  endfunction

  // Weight address for tap (i,j) is i*3 + j.
  function automatic logic [3:0] flt_addr(
    input logic [1:0] i,
    input logic [1:0] j
  );
    return {1'b0, i, 1'b0} + {2'b00, i} + {2'b00, j};
  endfunction

  // NOTE: every signal assigned in this block gets a value before any branch,
  // so the logic stays purely combinational and no latch is inferred.
  always_comb begin
    nx_win   = win;
    nx_ti    = ti;
    nx_tj    = tj + 2'd1;
    last_tap = 1'b0;
    if (tj == 2'd2) begin
      nx_tj = 2'd0;
      if (ti == 2'd2) begin
        nx_ti    = 2'd0;
        nx_win   = win + 2'd1;
        last_tap = (win == 2'd3);
      end else begin
        nx_ti = ti + 2'd1;
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments.
  // Each register then updates from values sampled before the edge,
  // regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      ld_idx       <= '0;
      win          <= '0;
      ti           <= '0;
      tj           <= '0;
      // NOTE: the pixel/weight stores are reset along with everything else.
      // An abandoned job then leaves no stale operands behind.
      for (int k = 0; k < 16; k++) img[k] <= '0;
      for (int k = 0; k < 9; k++)  flt[k] <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.ld_ready <= 1'b0;
      bus.mac_en   <= 1'b0;
      bus.mac_clr  <= 1'b0;
      bus.mac_a    <= '0;
      bus.mac_b    <= '0;
      o00          <= '0;
      o01          <= '0;
      o10          <= '0;
      o11          <= '0;
    end else begin
      done <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_LOAD;
            busy         <= 1'b1;
            bus.ld_ready <= 1'b1;
            ld_idx       <= '0;
          end
        end

        ST_LOAD: begin
          // ld_ready is high for the whole of LOAD.
          // So ld_valid alone marks an accepted word.
          if (bus.ld_valid) begin
            // Indices 16..24 map to weights 0..8 through their low four bits.
            if (!ld_idx[4]) img[ld_idx[3:0]] <= bus.ld_data;
            else            flt[ld_idx[3:0]] <= bus.ld_data;

            if (ld_idx == 5'd24) begin
              // The first tap reads img[0] and flt[0].
              // Both were stored on earlier edges, so it can be issued now.
              state        <= ST_RUN;
              bus.ld_ready <= 1'b0;
              win          <= '0;
              ti           <= '0;
              tj           <= '0;
              bus.mac_en   <= 1'b1;
              bus.mac_clr  <= 1'b1;
              bus.mac_a    <= img[0];
              bus.mac_b    <= flt[0];
            end else begin
              ld_idx <= ld_idx + 5'd1;
            end
          end
        end

        ST_RUN: begin
          // A clear tap of window k>0 is the cycle where window k-1's sum
          // sits in the accumulator.
          if (ti == 2'd0 && tj == 2'd0) begin
            case (win)
              2'd1:    o00 <= acc_lo;
              2'd2:    o01 <= acc_lo;
              2'd3:    o10 <= acc_lo;
              default: ;
            endcase
          end

          if (last_tap) begin
            state       <= ST_WAIT;
            bus.mac_en  <= 1'b0;
            bus.mac_clr <= 1'b0;
            bus.mac_a   <= '0;
            bus.mac_b   <= '0;
          end else begin
            win         <= nx_win;
            ti          <= nx_ti;
            tj          <= nx_tj;
            bus.mac_clr <= (nx_ti == 2'd0) && (nx_tj == 2'd0);
            bus.mac_a   <= img[pix_addr(nx_win, nx_ti, nx_tj)];
            bus.mac_b   <= flt[flt_addr(nx_ti, nx_tj)];
          end
        end

        ST_WAIT: begin
          o11   <= acc_lo;
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv3x3_sequencer
//
// Directed bench for conv3x3_sequencer.
// A behavioural MAC model sits on the slave side of the interface.
// Each job pushes its expected tap stream and expected results into queues.
// Those are popped when the DUT presents taps and when it pulses done.
// -----------------------------------------------------------------------------
module tb_conv3x3_sequencer;

  localparam int DW = 8;
  localparam int AW = 20;

  typedef struct packed {
    logic          clr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } tap_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [DW-1:0] o00, o01, o10, o11;

  conv3x3_sequencer_if #(.DW(DW), .AW(AW)) bus ();

  conv3x3_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master),
    .o00   (o00),
    .o01   (o01),
    .o10   (o10),
    .o11   (o11)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Shared MAC datapath model.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] mac_prod;
  assign mac_prod = AW'(bus.mac_a) * AW'(bus.mac_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            bus.mac_acc <= '0;
    else if (bus.mac_en) bus.mac_acc <= bus.mac_clr ? mac_prod : bus.mac_acc + mac_prod;
  end

  // ---------------------------------------------------------------------------
  // Monitors.
  // These sample on the falling edge and keep running totals.
  // The directed sequence takes deltas of these totals per job.
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  int            tap_total = 0;
  int            acc_total = 0;
  int            done_total = 0;
  int            load_mac_bad = 0;
  int            idle_mac_bad = 0;
  logic [AW-1:0] max_acc = '0;
  tap_t          obs_log [0:511];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mac_en === 1'b1) begin
      if (tap_total < 512) obs_log[tap_total] <= '{clr: bus.mac_clr, a: bus.mac_a, b: bus.mac_b};
      tap_total <= tap_total + 1;
    end
    if (bus.ld_valid === 1'b1 && bus.ld_ready === 1'b1) acc_total <= acc_total + 1;
    if (done === 1'b1) done_total <= done_total + 1;
    if (bus.mac_en === 1'b1 && bus.ld_ready === 1'b1) load_mac_bad <= load_mac_bad + 1;
    if (bus.mac_en !== 1'b1 && (bus.mac_a !== '0 || bus.mac_b !== '0 || bus.mac_clr !== 1'b0))
      idle_mac_bad <= idle_mac_bad + 1;
    if (bus.mac_acc > max_acc) max_acc <= bus.mac_acc;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard queues, stimulus data, checking.
  // ---------------------------------------------------------------------------
  tap_t        tap_q [$];
  logic [31:0] res_q [$];

  logic [7:0] nom_w [25] = '{8, 3, 9, 1,  7, 7, 2, 8,  5, 6, 3, 1,  4, 9, 2, 6,
                            1, 5, 8,  6, 0, 7,  3, 1, 2};
  logic [7:0] job_w [25];

  localparam logic [31:0] NOM_RES   = {8'd178, 8'd177, 8'd134, 8'd165};
  localparam logic [31:0] TRUNC_RES = {8'd9, 8'd9, 8'd9, 8'd9};

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  // Pulse start, then stream job_w.
  // stall=1 toggles ld_valid every cycle.
  // poke=1 also pulses start in the middle of LOAD.
  task automatic load_job(input bit stall, input bit poke, output int acc_edge, output int n_words);
    bit hand;
    bit tog;
    int guard;
    n_words  = 0;
    tog      = 1'b1;
    guard    = 0;
    acc_edge = -1000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n_words < 25 && guard < 200) begin
      bus.ld_valid = stall ? tog : 1'b1;
      bus.ld_data  = job_w[n_words];
      if (poke && guard == 7) start = 1'b1;
      @(negedge clk);
      hand = (bus.ld_valid === 1'b1) && (bus.ld_ready === 1'b1);
      if (hand && n_words == 24) acc_edge = cyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
      if (hand) n_words++;
      tog = !tog;
      guard++;
    end
    // ld_valid stays high into RUN; it must not be taken outside LOAD.
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hEE;
  endtask

  task automatic do_job(input bit stall, input bit poke, input logic [31:0] exp_res);
    int          b_tap, b_acc, b_done, b_lmb, b_imb;
    int          acc_edge, n_words;
    bit          seen;
    logic [31:0] exp;
    tap_t        et;

    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            tap_q.push_back('{clr: (i == 0 && j == 0),
                              a:   job_w[(r + i) * 4 + c + j],
                              b:   job_w[16 + i * 3 + j]});
    res_q.push_back(exp_res);

    b_tap  = tap_total;
    b_acc  = acc_total;
    b_done = done_total;
    b_lmb  = load_mac_bad;
    b_imb  = idle_mac_bad;

    load_job(stall, poke, acc_edge, n_words);
    check("load_words_driven", n_words, 25);

    if (poke) begin
      repeat (10) @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end

    seen = 1'b0;
    for (int k = 0; k < 120 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    exp = res_q.pop_front();
    if (seen) begin
      // The accept edge closes cycle N; done sits in cycle N+38, 37 edges later.
      check("done_latency_edges", cyc - acc_edge, 37);
      check("o00", o00, exp[31:24]);
      check("o01", o01, exp[23:16]);
      check("o10", o10, exp[15:8]);
      check("o11", o11, exp[7:0]);
      check("busy_in_done", busy, 0);
      if (poke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
    end
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    repeat (3) @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_ld_ready", bus.ld_ready, 0);

    check("tap_count", tap_total - b_tap, 36);
    for (int k = 0; k < 36; k++) begin
      et = tap_q.pop_front();
      check($sformatf("tap%0d", k + 1), obs_log[b_tap + k], et);
    end
    check("words_accepted", acc_total - b_acc, 25);
    check("done_pulses", done_total - b_done, 1);
    check("mac_en_in_load", load_mac_bad - b_lmb, 0);
    check("operands_zero_when_idle", idle_mac_bad - b_imb, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  b_tap, b_done, acc_edge, n_words;
    bit  found;

    rst          = 1'b1;
    start        = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    #2 rst = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ld_ready", bus.ld_ready, 0);
    check("rst_mac_en", bus.mac_en, 0);
    check("rst_mac_ops", {bus.mac_clr, bus.mac_a, bus.mac_b}, 0);
    check("rst_outputs", {o00, o01, o10, o11}, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Nominal job, ld_valid always high.
    job_w = nom_w;
    do_job(1'b0, 1'b0, NOM_RES);

    // Truncation job.
    // A stray load word is offered in IDLE first; it must be ignored.
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h77;
    repeat (3) @(posedge clk); #1;
    check("idle_no_ready", bus.ld_ready, 0);
    check("idle_not_busy", busy, 0);
    for (int k = 0; k < 25; k++) job_w[k] = 8'd255;
    do_job(1'b0, 1'b0, TRUNC_RES);
    check("trunc_peak_acc", max_acc, 585225);

    // Stalled load with start pulses in LOAD, RUN and DONE.
    job_w = nom_w;
    do_job(1'b1, 1'b1, NOM_RES);

    // Reset at tap 20 of a run, then a full job.
    job_w  = nom_w;
    b_tap  = tap_total;
    b_done = done_total;
    load_job(1'b0, 1'b0, acc_edge, n_words);
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (bus.mac_en === 1'b1 && tap_total - b_tap == 19) found = 1'b1;
    end
    check("abort_reached_tap20", found, 1);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ld_ready", bus.ld_ready, 0);
    check("abort_mac_en", bus.mac_en, 0);
    check("abort_mac_ops", {bus.mac_clr, bus.mac_a, bus.mac_b}, 0);
    check("abort_outputs", {o00, o01, o10, o11}, 0);
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (45) @(posedge clk); #1;
    check("abort_no_done", done_total - b_done, 0);
    check("abort_idle_busy", busy, 0);
    do_job(1'b0, 1'b0, NOM_RES);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv3x3_sequencer.md
CONV3X3_SEQUENCER -- requirements
Module: conv3x3_sequencer

Interface
REQ-001 Parameter DW, default 8: pixel, weight and result width.
REQ-002 Parameter AW, default 20: MAC accumulator width; AW >= 2*DW+4 SHALL hold.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  pulse; begins a job when in IDLE.
REQ-006 busy  output  1  high in LOAD, RUN, WAIT.
REQ-007 done  output  1  one-cycle pulse when all four results are valid.
REQ-008 ld_valid  input  1  load word present.
REQ-009 ld_ready  output  1  sequencer accepts a load word (high only in LOAD).
REQ-010 ld_data  input  DW  load word: 16 image pixels row-major, then 9 filter weights row-major.
REQ-011 mac_en  output  1  tap valid to the shared MAC datapath.
REQ-012 mac_clr  output  1  with mac_en: MAC computes acc = a*b instead of acc + a*b.
REQ-013 mac_a  output  DW  pixel operand.
REQ-014 mac_b  output  DW  weight operand.
REQ-015 mac_acc  input  AW  MAC registered accumulator; updates one edge after mac_en.
REQ-016 o00, o01, o10, o11  output  DW each  2x2 valid-convolution results.

Function
REQ-017 States SHALL be IDLE, LOAD, RUN, WAIT, DONE.
REQ-018 IDLE: start=1 -> LOAD next cycle; start in any other state SHALL be ignored.
REQ-019 LOAD: word accepted on each edge with ld_valid & ld_ready; word index 0..24 stored to img[0..15] then flt[0..8]; ld_valid low stalls the index.
REQ-020 LOAD -> RUN on the edge accepting word 24; ld_valid outside LOAD SHALL have no effect.
REQ-021 RUN SHALL last exactly 36 cycles with mac_en=1 every cycle: windows (r,c) in order (0,0),(0,1),(1,0),(1,1), taps (i,j) row-major within each window.
REQ-022 Per tap: mac_a = img[(r+i)*4 + (c+j)], mac_b = flt[i*3+j]; mac_clr=1 only on tap (0,0) of each window.
REQ-023 Window k result SHALL be captured from mac_acc in the cycle after its 9th tap (coinciding with the next window's clr tap); captured value = mac_acc[DW-1:0] (truncation, no saturation).
REQ-024 RUN -> WAIT after tap 36; WAIT (1 cycle, mac_en=0) captures o11; WAIT -> DONE; DONE (1 cycle) drives done=1 -> IDLE.
REQ-025 Latency: last load word accepted at edge N -> done high in cycle N+38.
REQ-026 Outputs o** SHALL hold their value until overwritten by the next job's capture; mac_a/mac_b/mac_clr SHALL be 0 whenever mac_en=0.
REQ-027 start asserted in DONE is ignored; a new start is honoured from IDLE only (earliest one cycle after done).

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, counters 0, img/flt 0, busy=done=ld_ready=mac_en=mac_clr=0, mac_a=mac_b=0, o00..o11=0.
REQ-029 Reset mid-job (any state) SHALL abandon the job with no done pulse; operation resumes from IDLE after rst returns to 1.

Verification
REQ-030 Nominal: img rows {8,3,9,1},{7,7,2,8},{5,6,3,1},{4,9,2,6}, flt rows {1,5,8},{6,0,7},{3,1,2}, ld_valid always 1 -> o00=178, o01=177, o10=134, o11=165, done 38 cycles after last load word, busy low after done.
REQ-031 Truncation: all pixels and weights 255 -> mac_acc peak 585225, every output 9.
REQ-032 Load stall: ld_valid toggled 1/0 each cycle -> exactly 25 words accepted, same results as REQ-030; mac_en never high during LOAD.
REQ-033 Tap order: bench checks 36 (mac_a, mac_b, mac_clr) triples against REQ-022 for REQ-030 data; mac_clr on taps 1, 10, 19, 28 only.
REQ-034 Reset mid-RUN at tap 20 -> all outputs 0 immediately, no done; a following full job gives REQ-030 results.
REQ-035 start pulsed during LOAD, RUN and DONE -> ignored; exactly one done per job.
